// File: rtl/counter_mod.sv
// rtl/counter_mod.sv - parametrised modulo up/down counter with load, terminal-count pulse and sticky overflow
module counter_mod #(
    parameter int WIDTH   = 11,
    parameter int MAX     = 4,
    parameter int K       = 1,
    parameter int WRAP_UP = 0,
    parameter int WRAP_DN = MAX,
    parameter int EDGE    = 0
) (
    input  logic             CLKB,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             sig,
    output logic [WIDTH-1:0] cnt,
    output logic             full,
    output logic             empty,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $fatal(1, "counter_mod: WIDTH must be in 1..31");
    end
    if (MAX < 1 || longint'(MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
        $fatal(1, "counter_mod: MAX must be in 1..2^WIDTH-1");
    end
    if (K < 1 || K > MAX) begin : g_bad_k
        $fatal(1, "counter_mod: K must be in 1..MAX");
    end
    if (WRAP_UP < 0 || WRAP_UP > MAX || WRAP_DN < 0 || WRAP_DN > MAX) begin : g_bad_wrap
        $fatal(1, "counter_mod: WRAP_UP and WRAP_DN must be in 0..MAX");
    end

    localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] K_W       = WIDTH'(K);
    localparam logic [WIDTH:0]   MAX_X     = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   K_X       = (WIDTH+1)'(K);
    localparam logic [WIDTH-1:0] WRAP_UP_W = WIDTH'(WRAP_UP);
    localparam logic [WIDTH-1:0] WRAP_DN_W = WIDTH'(WRAP_DN);

    logic             sig_d;
    logic             q;
    logic             step;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] load_clamped;

    assign q            = (EDGE != 0) ? (sig & ~sig_d) : sig;
    assign step         = en & q;
    // One extra bit so cnt+K cannot alias back below MAX before the compare.
    assign sum          = {1'b0, cnt} + K_X;
    assign load_clamped = (load_val > MAX_W) ? MAX_W : load_val;

    assign full  = (cnt == MAX_W);
    assign empty = (cnt == '0);

    always_ff @(posedge CLKB or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
            tc    <= 1'b0;
            if (clr) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (load) begin
                cnt <= load_clamped;
            end else if (step) begin
                if (up) begin
                    if (sum <= MAX_X) begin
                        cnt <= sum[WIDTH-1:0];
                    end else begin
                        cnt <= WRAP_UP_W;
                        tc  <= 1'b1;
                        ovf <= 1'b1;
                    end
                end else begin
                    if (cnt >= K_W) begin
                        cnt <= cnt - K_W;
                    end else begin
                        cnt <= WRAP_DN_W;
                        tc  <= 1'b1;
                        ovf <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
// tb/tb_counter_mod.sv - self-checking bench for counter_mod over three parameter sets
module tb_counter_mod;

    typedef struct {
        int          id;
        string       tag;
        logic [10:0] cnt;
        logic        tc;
        logic        ovf;
    } exp_t;

    logic        CLKB;
    logic        rst_n;
    logic [2:0]  en_v, clr_v, load_v, up_v, sig_v;
    logic [10:0] lv_v  [3];
    logic [10:0] cnt_v [3];
    logic [2:0]  full_v, empty_v, tc_v, ovf_v;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // u_a: defaults; u_b: MAX=10, K=3; u_c: edge-qualified, MAX=4
    counter_mod u_a (
        .CLKB(CLKB), .rst_n(rst_n), .en(en_v[0]), .clr(clr_v[0]), .load(load_v[0]),
        .load_val(lv_v[0]), .up(up_v[0]), .sig(sig_v[0]), .cnt(cnt_v[0]),
        .full(full_v[0]), .empty(empty_v[0]), .tc(tc_v[0]), .ovf(ovf_v[0])
    );

    counter_mod #(.MAX(10), .K(3), .WRAP_UP(0), .WRAP_DN(10)) u_b (
        .CLKB(CLKB), .rst_n(rst_n), .en(en_v[1]), .clr(clr_v[1]), .load(load_v[1]),
        .load_val(lv_v[1]), .up(up_v[1]), .sig(sig_v[1]), .cnt(cnt_v[1]),
        .full(full_v[1]), .empty(empty_v[1]), .tc(tc_v[1]), .ovf(ovf_v[1])
    );

    counter_mod #(.EDGE(1)) u_c (
        .CLKB(CLKB), .rst_n(rst_n), .en(en_v[2]), .clr(clr_v[2]), .load(load_v[2]),
        .load_val(lv_v[2]), .up(up_v[2]), .sig(sig_v[2]), .cnt(cnt_v[2]),
        .full(full_v[2]), .empty(empty_v[2]), .tc(tc_v[2]), .ovf(ovf_v[2])
    );

    initial CLKB = 1'b0;
    always #5 CLKB = ~CLKB;

    function automatic int max_of(input int id);
        return (id == 1) ? 10 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_state(input int id, input string tag, input logic [10:0] ec,
                               input logic etc, input logic eovf);
        check({tag, "_cnt"},   32'(cnt_v[id]),   32'(ec));
        check({tag, "_tc"},    32'(tc_v[id]),    32'(etc));
        check({tag, "_ovf"},   32'(ovf_v[id]),   32'(eovf));
        check({tag, "_full"},  32'(full_v[id]),  32'(int'(ec) == max_of(id)));
        check({tag, "_empty"}, 32'(empty_v[id]), 32'(ec == 11'd0));
    endtask

    // Drive one cycle on instance id, queue its expected result, then compare after the edge.
    task automatic cyc(input int id, input string tag, input logic e, input logic u,
                       input logic s, input logic c, input logic l, input logic [10:0] lv,
                       input logic [10:0] ec, input logic etc, input logic eovf);
        exp_t x;
        en_v   = '0;
        clr_v  = '0;
        load_v = '0;
        en_v[id]   = e;
        up_v[id]   = u;
        sig_v[id]  = s;
        clr_v[id]  = c;
        load_v[id] = l;
        lv_v[id]   = lv;
        x.id = id; x.tag = tag; x.cnt = ec; x.tc = etc; x.ovf = eovf;
        sb.push_back(x);
        @(posedge CLKB);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            check_state(x.id, x.tag, x.cnt, x.tc, x.ovf);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en_v   = '0; clr_v = '0; load_v = '0; up_v = '0; sig_v = '0;
        for (int i = 0; i < 3; i++) lv_v[i] = '0;

        #12;
        for (int i = 0; i < 3; i++) check_state(i, $sformatf("rst%0d", i), 11'd0, 1'b0, 1'b0);
        @(posedge CLKB);
        #1;
        rst_n = 1'b1;

        // Default up count with wrap through MAX=4
        begin
            logic [10:0] seq [6] = '{11'd1, 11'd2, 11'd3, 11'd4, 11'd0, 11'd1};
            for (int i = 0; i < 6; i++)
                cyc(0, $sformatf("up%0d", i), 1, 1, 1, 0, 0, 0, seq[i], i == 4, i >= 4);
        end

        // K=3, MAX=10: 9+3 wraps to 0, never 12
        cyc(1, "k3_0", 1, 1, 1, 0, 0, 0, 11'd3, 0, 0);
        cyc(1, "k3_1", 1, 1, 1, 0, 0, 0, 11'd6, 0, 0);
        cyc(1, "k3_2", 1, 1, 1, 0, 0, 0, 11'd9, 0, 0);
        cyc(1, "k3_3", 1, 1, 1, 0, 0, 0, 11'd0, 1, 1);
        cyc(1, "k3_clr", 1, 1, 1, 1, 0, 0, 11'd0, 0, 0);

        // Down count from 0 wraps to WRAP_DN=4
        cyc(0, "dn_clr", 0, 0, 0, 1, 0, 0, 11'd0, 0, 0);
        begin
            logic [10:0] seq [6] = '{11'd4, 11'd3, 11'd2, 11'd1, 11'd0, 11'd4};
            for (int i = 0; i < 6; i++)
                cyc(0, $sformatf("dn%0d", i), 1, 0, 1, 0, 0, 0, seq[i], i == 0 || i == 5, 1);
        end

        // Edge qualification: 5 high, 2 low, 1 high -> two increments
        begin
            logic        sseq [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
            logic [10:0] ce   [8] = '{11'd1, 11'd1, 11'd1, 11'd1, 11'd1, 11'd1, 11'd1, 11'd2};
            logic [10:0] ae   [8] = '{11'd1, 11'd2, 11'd3, 11'd4, 11'd0, 11'd0, 11'd0, 11'd1};
            for (int i = 0; i < 8; i++)
                cyc(2, $sformatf("edg%0d", i), 1, 1, sseq[i], 0, 0, 0, ce[i], 0, 0);
            cyc(0, "lvl_clr", 0, 1, 0, 1, 0, 0, 11'd0, 0, 0);
            for (int i = 0; i < 8; i++)
                cyc(0, $sformatf("lvl%0d", i), 1, 1, sseq[i], 0, 0, 0, ae[i], i == 4, i >= 4);
        end

        // Same-cycle priority: load beats step, clr beats load, load clamps to MAX
        cyc(0, "ld_step", 1, 1, 1, 0, 1, 11'd2, 11'd2, 0, 1);
        cyc(0, "clr_ld", 1, 1, 1, 1, 1, 11'd3, 11'd0, 0, 0);
        cyc(0, "ld_clamp", 0, 1, 0, 0, 1, 11'd15, 11'd4, 0, 0);
        cyc(0, "ld_nowrap", 1, 1, 1, 0, 1, 11'd1, 11'd1, 0, 0);
        cyc(0, "hold", 0, 1, 1, 0, 0, 0, 11'd1, 0, 0);

        // Asynchronous reset between edges
        cyc(1, "ar0", 1, 1, 1, 0, 0, 0, 11'd3, 0, 0);
        cyc(1, "ar1", 1, 1, 1, 0, 0, 0, 11'd6, 0, 0);
        cyc(1, "ar2", 1, 1, 1, 0, 0, 0, 11'd9, 0, 0);
        cyc(1, "ar3", 1, 1, 1, 0, 0, 0, 11'd0, 1, 1);
        cyc(1, "ar4", 1, 1, 1, 0, 0, 0, 11'd3, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_state(1, "arst_b", 11'd0, 1'b0, 1'b0);
        check_state(0, "arst_a", 11'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        cyc(1, "resume0", 1, 1, 1, 0, 0, 0, 11'd3, 0, 0);
        cyc(1, "resume1", 1, 1, 1, 0, 0, 0, 11'd6, 0, 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
